mem_access_ctrl: RTL and testbench

Request sequencer that sits directly upstream of the data memory and is the only block that drives its enable, ReadWrite, Address and DataIn pins. It accepts single load/store requests from the core over a valid/ready handshake and runs exactly one memory access per request. It holds the memory pins stable for the required number of cycles and captures DataOut. It returns one response per request over a second valid/ready handshake and keeps saturating read/write transaction counters for debug.

---
 rtl/mem_access_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_ctrl
//  Brief    : Single-outstanding load/store sequencer in front of the data
//             memory. Accepts one request, runs one memory access with the
//             pins held for the required number of cycles, returns one
//             response, and keeps saturating read/write counters for debug.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_access_ctrl #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 3,
  parameter int READ_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  // request channel
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  // response channel
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  // memory pins
  output logic              mem_enable,
  output logic              mem_readwrite,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_datain,
  input  logic [DATA_W-1:0] mem_dataout,
  // debug counters
  output logic [CNT_W-1:0]  rd_count,
  output logic [CNT_W-1:0]  wr_count
);

  // The WAIT down-counter is preloaded with READ_LAT-2 and expires at zero,
  // so WAIT lasts READ_LAT-1 cycles. Keep at least one bit for READ_LAT<=2.
  localparam int c_wait_w = (READ_LAT > 2) ? $clog2(READ_LAT - 1) : 1;
  localparam logic [c_wait_w-1:0] c_wait_init =
    c_wait_w'((READ_LAT > 1) ? (READ_LAT - 2) : 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;

  logic                r_write;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic [c_wait_w-1:0] r_wait_cnt;
  logic [CNT_W-1:0]    r_rd_count;
  logic [CNT_W-1:0]    r_wr_count;

  // State register; reset drops any in-flight transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and state-decoded outputs. Memory pins are only driven
  // active in ACCESS/WAIT, so a load can never present a write.
  always_comb begin
    w_next        = r_state;
    req_ready     = 1'b0;
    rsp_valid     = 1'b0;
    mem_enable    = 1'b0;
    mem_readwrite = 1'b1;
    mem_datain    = '0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_next = ACCESS;
        end
      end
      ACCESS: begin
        mem_enable    = 1'b1;
        mem_readwrite = ~r_write;
        mem_datain    = r_write ? r_wdata : '0;
        if (r_write || (READ_LAT <= 1)) begin
          w_next = RESP;
        end else begin
          w_next = WAIT;
        end
      end
      WAIT: begin
        mem_enable    = 1'b1;
        mem_readwrite = ~r_write;
        mem_datain    = r_write ? r_wdata : '0;
        if (r_wait_cnt == '0) begin
          w_next = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Request capture, read-data sampling and the WAIT down-counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_write    <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_wait_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_write <= req_write;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
          end
        end
        ACCESS: begin
          if (r_write) begin
            r_rdata <= '0;
          end else if (READ_LAT <= 1) begin
            r_rdata <= mem_dataout;
          end else begin
            r_wait_cnt <= c_wait_init;
          end
        end
        WAIT: begin
          if (r_wait_cnt == '0) begin
            r_rdata <= mem_dataout;
          end else begin
            r_wait_cnt <= r_wait_cnt - 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Saturating transaction counters, bumped on the response handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_count <= '0;
      r_wr_count <= '0;
    end else if ((r_state == RESP) && rsp_ready) begin
      if (r_write) begin
        if (r_wr_count != {CNT_W{1'b1}}) begin
          r_wr_count <= r_wr_count + 1'b1;
        end
      end else begin
        if (r_rd_count != {CNT_W{1'b1}}) begin
          r_rd_count <= r_rd_count + 1'b1;
        end
      end
    end
  end

  assign mem_address = r_addr;
  assign rsp_write   = r_write;
  assign rsp_rdata   = r_rdata;
  assign rd_count    = r_rd_count;
  assign wr_count    = r_wr_count;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_access_ctrl
//  Brief    : Directed bench. Instance A: READ_LAT=1, CNT_W=2 (store/load
//             back, back-pressure, saturation). Instance B: READ_LAT=3,
//             CNT_W=16 (latency sweep, reset mid-load).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_ctrl;

  localparam int LAT_A = 1;
  localparam int LAT_B = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- instance A ----------------
  logic        rst_a, a_req_valid, a_req_ready, a_req_write;
  logic [2:0]  a_req_addr;
  logic [31:0] a_req_wdata;
  logic        a_rsp_valid, a_rsp_ready, a_rsp_write;
  logic [31:0] a_rsp_rdata;
  logic        a_mem_enable, a_mem_readwrite;
  logic [2:0]  a_mem_address;
  logic [31:0] a_mem_datain, a_mem_dataout;
  logic [1:0]  a_rd_count, a_wr_count;

  mem_access_ctrl #(.DATA_W(32), .ADDR_W(3), .READ_LAT(LAT_A), .CNT_W(2)) u_dut_a (
    .clk(clk), .rst(rst_a),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_write(a_rsp_write),
    .rsp_rdata(a_rsp_rdata),
    .mem_enable(a_mem_enable), .mem_readwrite(a_mem_readwrite),
    .mem_address(a_mem_address), .mem_datain(a_mem_datain), .mem_dataout(a_mem_dataout),
    .rd_count(a_rd_count), .wr_count(a_wr_count)
  );

  // ---------------- instance B ----------------
  logic        rst_b, b_req_valid, b_req_ready, b_req_write;
  logic [2:0]  b_req_addr;
  logic [31:0] b_req_wdata;
  logic        b_rsp_valid, b_rsp_ready, b_rsp_write;
  logic [31:0] b_rsp_rdata;
  logic        b_mem_enable, b_mem_readwrite;
  logic [2:0]  b_mem_address;
  logic [31:0] b_mem_datain, b_mem_dataout;
  logic [15:0] b_rd_count, b_wr_count;

  mem_access_ctrl #(.DATA_W(32), .ADDR_W(3), .READ_LAT(LAT_B), .CNT_W(16)) u_dut_b (
    .clk(clk), .rst(rst_b),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_write(b_rsp_write),
    .rsp_rdata(b_rsp_rdata),
    .mem_enable(b_mem_enable), .mem_readwrite(b_mem_readwrite),
    .mem_address(b_mem_address), .mem_datain(b_mem_datain), .mem_dataout(b_mem_dataout),
    .rd_count(b_rd_count), .wr_count(b_wr_count)
  );

  // Memory models: preload on reset, write on enabled write cycles, and
  // return valid read data only once the pins have been held LAT cycles.
  logic [31:0] mem_a [8];
  logic [31:0] mem_b [8];
  int          a_hold = 0, a_en_cyc = 0, a_wr_cyc = 0;
  int          b_hold = 0, b_en_cyc = 0, b_wr_cyc = 0;
  logic [2:0]  a_last_waddr = 3'd0;
  logic [31:0] a_last_wdata = 32'd0;

  always @(posedge clk) begin
    if (rst_a) begin
      for (int i = 0; i < 8; i++) mem_a[i] <= 32'(i);
    end else if (a_mem_enable && !a_mem_readwrite) begin
      mem_a[a_mem_address] <= a_mem_datain;
    end
    a_hold <= a_mem_enable ? a_hold + 1 : 0;
    if (a_mem_enable) a_en_cyc <= a_en_cyc + 1;
    if (a_mem_enable && !a_mem_readwrite) begin
      a_wr_cyc     <= a_wr_cyc + 1;
      a_last_waddr <= a_mem_address;
      a_last_wdata <= a_mem_datain;
    end
  end

  always @(posedge clk) begin
    if (rst_b) begin
      for (int i = 0; i < 8; i++) mem_b[i] <= 32'hC0DE_0000 | 32'(i);
    end else if (b_mem_enable && !b_mem_readwrite) begin
      mem_b[b_mem_address] <= b_mem_datain;
    end
    b_hold <= b_mem_enable ? b_hold + 1 : 0;
    if (b_mem_enable) b_en_cyc <= b_en_cyc + 1;
    if (b_mem_enable && !b_mem_readwrite) b_wr_cyc <= b_wr_cyc + 1;
  end

  assign a_mem_dataout = (a_mem_enable && a_mem_readwrite && a_hold >= LAT_A - 1)
                         ? mem_a[a_mem_address] : 32'hBAD0_0BAD;
  assign b_mem_dataout = (b_mem_enable && b_mem_readwrite && b_hold >= LAT_B - 1)
                         ? mem_b[b_mem_address] : 32'hBAD0_0BAD;

  // Single comparison point for every check in the bench.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One transaction on instance A; bp = cycles rsp_ready is held low while a
  // competing request is offered. Returns observed latency (ACCESS=1).
  task automatic a_txn(input logic w, input logic [2:0] addr, input logic [31:0] wd,
                       input int bp, input logic [31:0] exp_rd,
                       output logic [31:0] rd, output logic rw_echo, output int lat);
    int n;
    @(negedge clk);
    a_req_write = w; a_req_addr = addr; a_req_wdata = wd; a_req_valid = 1'b1;
    n = 0;
    while (!a_req_ready && n < 20) begin @(negedge clk); n++; end
    chk("a_req_timeout", 32'(n < 20), 32'd1);
    @(negedge clk);
    a_req_valid = 1'b0;
    lat = 1;
    while (!a_rsp_valid && lat < 20) begin @(negedge clk); lat++; end
    chk("a_rsp_timeout", 32'(lat < 20), 32'd1);
    rd = a_rsp_rdata; rw_echo = a_rsp_write;
    for (int i = 0; i < bp; i++) begin
      a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 3'd0; a_req_wdata = 32'hFFFF_FFFF;
      @(negedge clk);
      chk("bp_rsp_valid", 32'(a_rsp_valid), 32'd1);
      chk("bp_rsp_rdata", a_rsp_rdata, exp_rd);
      chk("bp_mem_enable", 32'(a_mem_enable), 32'd0);
      chk("bp_req_ready", 32'(a_req_ready), 32'd0);
    end
    a_req_valid = 1'b0; a_rsp_ready = 1'b1;
    @(negedge clk);
    a_rsp_ready = 1'b0;
  endtask

  task automatic a_reset();
    rst_a = 1'b1;
    repeat (2) @(negedge clk);
    rst_a = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        rw;
    int          lat, en0, wr0, n, hs, prev_hs, seen;
    bit          got;

    rst_a = 1'b1; a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 3'd3;
    a_req_wdata = 32'h1234_5678; a_rsp_ready = 1'b0;
    rst_b = 1'b1; b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = 3'd0;
    b_req_wdata = 32'd0; b_rsp_ready = 1'b0;

    // ---- reset values with req_valid held high ----
    @(negedge clk);
    chk("rst1_req_ready", 32'(a_req_ready), 32'd1);
    chk("rst1_mem_enable", 32'(a_mem_enable), 32'd0);
    @(negedge clk);
    chk("rst2_req_ready", 32'(a_req_ready), 32'd1);
    chk("rst_outs", {27'd0, a_rsp_valid, a_rsp_write, a_mem_enable, a_mem_readwrite, 1'b0}, 32'h2);
    chk("rst_rsp_rdata", a_rsp_rdata, 32'd0);
    chk("rst_mem_address", 32'(a_mem_address), 32'd0);
    chk("rst_mem_datain", a_mem_datain, 32'd0);
    chk("rst_counts", {28'd0, a_rd_count, a_wr_count}, 32'd0);
    rst_a = 1'b0; a_req_valid = 1'b0; rst_b = 1'b0;
    @(negedge clk);
    chk("post_rst_req_ready", 32'(a_req_ready), 32'd1);
    chk("rst_no_enable_pulse", 32'(a_en_cyc), 32'd0);

    // ---- store 0xDEADBEEF to addr 5 ----
    en0 = a_en_cyc; wr0 = a_wr_cyc;
    a_txn(1'b1, 3'd5, 32'hDEAD_BEEF, 0, 32'd0, rd, rw, lat);
    chk("st_en_cycles", 32'(a_en_cyc - en0), 32'd1);
    chk("st_wr_cycles", 32'(a_wr_cyc - wr0), 32'd1);
    chk("st_waddr", 32'(a_last_waddr), 32'd5);
    chk("st_wdata", a_last_wdata, 32'hDEAD_BEEF);
    chk("st_latency", 32'(lat), 32'd2);
    chk("st_rsp_write", 32'(rw), 32'd1);
    chk("st_rsp_rdata", rd, 32'd0);
    chk("st_wr_count", 32'(a_wr_count), 32'd1);
    chk("st_req_ready_back", 32'(a_req_ready), 32'd1);

    // ---- load back addr 5 ----
    en0 = a_en_cyc; wr0 = a_wr_cyc;
    a_txn(1'b0, 3'd5, 32'd0, 0, 32'hDEAD_BEEF, rd, rw, lat);
    chk("ld_rdata", rd, 32'hDEAD_BEEF);
    chk("ld_rsp_write", 32'(rw), 32'd0);
    chk("ld_latency", 32'(lat), 32'd2);
    chk("ld_en_cycles", 32'(a_en_cyc - en0), 32'd1);
    chk("ld_no_write", 32'(a_wr_cyc - wr0), 32'd0);
    chk("ld_counts", {28'd0, a_rd_count, a_wr_count}, 32'h5);

    // ---- back-pressure load from addr 7 ----
    wr0 = a_wr_cyc;
    a_txn(1'b0, 3'd7, 32'd0, 4, 32'h0000_0007, rd, rw, lat);
    chk("bp_rdata", rd, 32'h0000_0007);
    chk("bp_no_second_req", 32'(a_wr_cyc - wr0), 32'd0);
    chk("bp_counts", {28'd0, a_rd_count, a_wr_count}, 32'h9);
    chk("bp_idle_enable", 32'(a_mem_enable), 32'd0);

    // ---- saturation of the 2-bit write counter ----
    a_reset();
    chk("sat_rst_counts", {28'd0, a_rd_count, a_wr_count}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      a_txn(1'b1, 3'(i), 32'h100 + 32'(i), 0, 32'd0, rd, rw, lat);
      chk("sat_wr_count", 32'(a_wr_count), (i + 1 > 3) ? 32'd3 : 32'(i + 1));
      chk("sat_rd_count", 32'(a_rd_count), 32'd0);
    end

    // ---- READ_LAT=3 back-to-back load sweep ----
    @(negedge clk);
    b_rsp_ready = 1'b1;
    prev_hs = 0;
    for (int i = 0; i < 8; i++) begin
      b_req_valid = 1'b1; b_req_write = 1'b0; b_req_addr = 3'(i); b_req_wdata = 32'd0;
      n = 0;
      while (!b_req_ready && n < 20) begin @(negedge clk); n++; end
      chk("b_req_timeout", 32'(n < 20), 32'd1);
      hs = cyc;
      if (i > 0) chk("b_hs_gap", 32'(hs - prev_hs), 32'd5);
      prev_hs = hs;
      en0 = b_en_cyc;
      got = 1'b0;
      for (int j = 0; j < 10 && !got; j++) begin
        @(negedge clk);
        if (b_mem_enable) begin
          chk("b_pin_addr", 32'(b_mem_address), 32'(i));
          chk("b_pin_rw", 32'(b_mem_readwrite), 32'd1);
        end
        if (b_rsp_valid) begin
          got = 1'b1;
          chk("b_rdata", b_rsp_rdata, 32'hC0DE_0000 | 32'(i));
          chk("b_rsp_write", 32'(b_rsp_write), 32'd0);
          chk("b_en_cycles", 32'(b_en_cyc - en0), 32'd3);
        end
      end
      chk("b_rsp_seen", 32'(got), 32'd1);
      @(negedge clk);
    end
    b_req_valid = 1'b0;
    chk("b_rd_count_sweep", 32'(b_rd_count), 32'd8);
    chk("b_no_writes", 32'(b_wr_cyc), 32'd0);

    // ---- reset during WAIT ----
    b_rsp_ready = 1'b0;
    @(negedge clk);
    b_req_valid = 1'b1; b_req_addr = 3'd2;
    n = 0;
    while (!b_req_ready && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    b_req_valid = 1'b0;
    @(negedge clk);
    chk("b_wait_enable", 32'(b_mem_enable), 32'd1);
    rst_b = 1'b1;
    @(negedge clk);
    rst_b = 1'b0;
    chk("b_rst_enable", 32'(b_mem_enable), 32'd0);
    chk("b_rst_rsp_valid", 32'(b_rsp_valid), 32'd0);
    chk("b_rst_req_ready", 32'(b_req_ready), 32'd1);
    b_rsp_ready = 1'b1;
    seen = 0;
    repeat (6) begin @(negedge clk); if (b_rsp_valid) seen = 1; end
    chk("b_no_rsp_after_rst", 32'(seen), 32'd0);
    chk("b_rd_count_after_rst", 32'(b_rd_count), 32'd0);

    // ---- next load after reset completes normally ----
    b_req_valid = 1'b1; b_req_addr = 3'd6;
    n = 0;
    while (!b_req_ready && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    b_req_valid = 1'b0;
    lat = 1;
    while (!b_rsp_valid && lat < 20) begin @(negedge clk); lat++; end
    chk("b_post_rst_latency", 32'(lat), 32'(LAT_B + 1));
    chk("b_post_rst_rdata", b_rsp_rdata, 32'hC0DE_0006);
    @(negedge clk);
    chk("b_post_rst_rd_count", 32'(b_rd_count), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
